banked_mem_ctrl: RTL

- Parametrised multi-channel segmented memory: NCH independent banks, one per pipeline client, each DEPTH words of WIDTH bits.
- Successor to the fixed 7-bank combinational-read memory.
- Adds registered reads with a valid strobe, byte-enable writes, out-of-range detection, and a post-reset clear engine.
- Sits between the pipeline's memory stages and storage.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_bank.sv | 64 ++++++
 rtl/banked_mem_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the banked memory controller
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int NCH_DEF   = 7;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 512;

    function automatic int byte_lanes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one bank with byte-enable write port and registered read
module mem_bank
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         we,
    input  logic [byte_lanes(WIDTH)-1:0] be,
    input  logic [AW-1:0]                a,
    input  logic [WIDTH-1:0]             wd,
    output logic [WIDTH-1:0]             rd,
    output logic                         rvalid,
    output logic                         err
);

    localparam int NB = byte_lanes(WIDTH);
    // One extra bit so DEPTH itself is representable for the bound check.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic             rvalid_q;
    logic             err_q;
    logic             in_range;

    // Addresses past the last word are flagged, never aliased onto real words.
    assign in_range = ({1'b0, a} < DEPTH_W);

    // Storage is deliberately not reset; only enabled bytes of in-range writes land.
    always_ff @(posedge clk) begin
        if (en && we && in_range) begin
            for (int l = 0; l < NB; l++) begin
                if (be[l]) begin
                    mem_q[a][l*8 +: 8] <= wd[l*8 +: 8];
                end
            end
        end
    end

    // Registered read path: data and strobes appear on the edge that samples the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= en & ~we;
            err_q    <= en & ~in_range;
            if (en && !we) begin
                rd_q <= in_range ? mem_q[a] : '0;
            end
        end
    end

    assign rd     = rd_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: rtl/banked_mem_ctrl.sv
// rtl/banked_mem_ctrl.sv - multi-channel banked memory with post-reset clear engine
module banked_mem_ctrl
    import mem_pkg::*;
#(
    parameter int NCH            = NCH_DEF,
    parameter int WIDTH          = WIDTH_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NCH-1:0]                     req,
    input  logic [NCH-1:0]                     we,
    input  logic [NCH*byte_lanes(WIDTH)-1:0]   be,
    input  logic [NCH*AW-1:0]                  a,
    input  logic [NCH*WIDTH-1:0]               wd,
    output logic                               ready,
    output logic [NCH*WIDTH-1:0]               rd,
    output logic [NCH-1:0]                     rvalid,
    output logic [NCH-1:0]                     err
);

    localparam int            NB          = byte_lanes(WIDTH);
    localparam state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [AW-1:0] LAST_WORD   = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          clearing;

    // State, clear counter and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Walk every word once in CLEAR, then settle in RUN until the next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            if (cnt_q == LAST_WORD) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        ready_d = (state_d == RUN);
    end

    assign clearing = (state_q == CLEAR);
    assign ready    = ready_q;

    // While clearing, the counter owns every bank port and client requests are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_bank
        logic             bank_en;
        logic             bank_we;
        logic [NB-1:0]    bank_be;
        logic [AW-1:0]    bank_a;
        logic [WIDTH-1:0] bank_wd;

        assign bank_en = clearing | (req[i] & ready_q);
        assign bank_we = clearing | we[i];
        assign bank_be = clearing ? {NB{1'b1}} : be[i*NB +: NB];
        assign bank_a  = clearing ? cnt_q : a[i*AW +: AW];
        assign bank_wd = clearing ? '0 : wd[i*WIDTH +: WIDTH];

        mem_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bank_en),
            .we     (bank_we),
            .be     (bank_be),
            .a      (bank_a),
            .wd     (bank_wd),
            .rd     (rd[i*WIDTH +: WIDTH]),
            .rvalid (rvalid[i]),
            .err    (err[i])
        );
    end

endmodule
